// File: rtl/sync_fifo_pkg.sv
// Shared constants, transfer encoding and elaboration-time geometry check
// for the synchronous FIFO controller.
package sync_fifo_pkg;

  localparam int DEF_ADDR_WIDTH      = 4;
  localparam int DEF_RAM_DEPTH       = 16;
  localparam int DEF_ALMOST_FULL_TH  = 14;
  localparam int DEF_ALMOST_EMPTY_TH = 2;

  typedef enum logic [1:0] {
    XFER_NONE  = 2'b00,
    XFER_READ  = 2'b01,
    XFER_WRITE = 2'b10,
    XFER_BOTH  = 2'b11
  } xfer_e;

  function automatic bit depth_matches_width(input int depth, input int addr_width);
    return depth == (32'sd1 << addr_width);
  endfunction

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Handshake bundle between the FIFO controller and its producer/consumer/RAM.
// almost_full/almost_empty exist only when SYNC_FIFO_ALMOST_EN is defined.
interface sync_fifo_ctrl_if #(
  parameter int ADDR_WIDTH = 4
);

  logic                  write_enable;
  logic                  read_enable;
  logic                  write_allow;
  logic                  read_allow;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic                  read_valid;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ADDR_WIDTH:0]   fifo_count;
  logic                  overflow;
  logic                  underflow;
`ifdef SYNC_FIFO_ALMOST_EN
  logic                  almost_full;
  logic                  almost_empty;

  modport master (
    output write_enable, read_enable,
    input  write_allow, read_allow, write_addr, read_addr, read_valid,
    input  fifo_full, fifo_empty, fifo_count, overflow, underflow,
    input  almost_full, almost_empty
  );

  modport slave (
    input  write_enable, read_enable,
    output write_allow, read_allow, write_addr, read_addr, read_valid,
    output fifo_full, fifo_empty, fifo_count, overflow, underflow,
    output almost_full, almost_empty
  );
`else
  modport master (
    output write_enable, read_enable,
    input  write_allow, read_allow, write_addr, read_addr, read_valid,
    input  fifo_full, fifo_empty, fifo_count, overflow, underflow
  );

  modport slave (
    input  write_enable, read_enable,
    output write_allow, read_allow, write_addr, read_addr, read_valid,
    output fifo_full, fifo_empty, fifo_count, overflow, underflow
  );
`endif

endinterface

// File: rtl/sync_fifo_ptr.sv
// One wrapping (ADDR_WIDTH+1)-bit FIFO pointer; the MSB is the wrap bit.
module sync_fifo_ptr #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                inc_en_i,
  output logic [ADDR_WIDTH:0] ptr_o
);

  logic [ADDR_WIDTH:0] ptr_q;
  logic [ADDR_WIDTH:0] ptr_d;

  always_comb begin
    if (inc_en_i) begin
      ptr_d = ptr_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Synchronous FIFO control stage driving a dual-port RAM: strobes, addresses,
// occupancy flags and pulses. Optional threshold flags: SYNC_FIFO_ALMOST_EN.
module sync_fifo_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int RAM_DEPTH       = DEF_RAM_DEPTH,
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int ALMOST_FULL_TH  = DEF_ALMOST_FULL_TH,
  parameter int ALMOST_EMPTY_TH = DEF_ALMOST_EMPTY_TH
) (
  input  logic             clock,
  input  logic             reset_n,
  sync_fifo_ctrl_if.slave  fifo
);

  generate
    if (!depth_matches_width(RAM_DEPTH, ADDR_WIDTH)) begin : g_bad_geometry
      $error("sync_fifo_ctrl: RAM_DEPTH must equal 2**ADDR_WIDTH");
    end
    if ((ALMOST_FULL_TH > RAM_DEPTH) || (ALMOST_EMPTY_TH > RAM_DEPTH)) begin : g_bad_threshold
      $error("sync_fifo_ctrl: almost thresholds must not exceed RAM_DEPTH");
    end
  endgenerate

  logic [ADDR_WIDTH:0] wr_ptr_s;
  logic [ADDR_WIDTH:0] rd_ptr_s;
  logic [ADDR_WIDTH:0] count_s;
  logic                full_s;
  logic                empty_s;
  logic                write_allow_s;
  logic                read_allow_s;

  logic read_valid_q, read_valid_d;
  logic overflow_q,   overflow_d;
  logic underflow_q,  underflow_d;

  sync_fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
    .clock    (clock),
    .reset_n  (reset_n),
    .inc_en_i (write_allow_s),
    .ptr_o    (wr_ptr_s)
  );

  sync_fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
    .clock    (clock),
    .reset_n  (reset_n),
    .inc_en_i (read_allow_s),
    .ptr_o    (rd_ptr_s)
  );

  // Flags come straight off the registered pointers so reset clears them with no edge.
  assign empty_s = (wr_ptr_s == rd_ptr_s);
  assign full_s  = (wr_ptr_s[ADDR_WIDTH] != rd_ptr_s[ADDR_WIDTH]) &&
                   (wr_ptr_s[ADDR_WIDTH-1:0] == rd_ptr_s[ADDR_WIDTH-1:0]);
  assign count_s = wr_ptr_s - rd_ptr_s;

  assign write_allow_s = fifo.write_enable & ~full_s;
  assign read_allow_s  = fifo.read_enable  & ~empty_s;

  always_comb begin
    read_valid_d = read_allow_s;
    overflow_d   = fifo.write_enable & full_s;
    underflow_d  = fifo.read_enable  & empty_s;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      read_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      read_valid_q <= read_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

`ifdef SYNC_FIFO_ALMOST_EN
  localparam logic [ADDR_WIDTH:0] AF_TH_C = ALMOST_FULL_TH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_TH_C = ALMOST_EMPTY_TH[ADDR_WIDTH:0];

  xfer_e               xfer_s;
  logic [ADDR_WIDTH:0] count_d;
  logic                almost_full_q,  almost_full_d;
  logic                almost_empty_q, almost_empty_d;

  assign xfer_s = xfer_e'({write_allow_s, read_allow_s});

  // Thresholds are judged on the post-edge occupancy so they move with fifo_count.
  always_comb begin
    count_d = count_s;
    case (xfer_s)
      XFER_WRITE: count_d = count_s + {{ADDR_WIDTH{1'b0}}, 1'b1};
      XFER_READ:  count_d = count_s - {{ADDR_WIDTH{1'b0}}, 1'b1};
      XFER_BOTH:  count_d = count_s;
      XFER_NONE:  count_d = count_s;
      default:    count_d = count_s;
    endcase
    almost_full_d  = (count_d >= AF_TH_C);
    almost_empty_d = (count_d <= AE_TH_C);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  assign fifo.almost_full  = almost_full_q;
  assign fifo.almost_empty = almost_empty_q;
`endif

  assign fifo.write_allow = write_allow_s;
  assign fifo.read_allow  = read_allow_s;
  assign fifo.write_addr  = wr_ptr_s[ADDR_WIDTH-1:0];
  assign fifo.read_addr   = rd_ptr_s[ADDR_WIDTH-1:0];
  assign fifo.fifo_full   = full_s;
  assign fifo.fifo_empty  = empty_s;
  assign fifo.fifo_count  = count_s;
  assign fifo.read_valid  = read_valid_q;
  assign fifo.overflow    = overflow_q;
  assign fifo.underflow   = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Scoreboard bench for sync_fifo_ctrl with a registered-read RAM model behind it.
module tb_sync_fifo_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  sync_fifo_ctrl_if #(.ADDR_WIDTH(AW)) fif ();

  sync_fifo_ctrl #(
    .RAM_DEPTH  (DEPTH),
    .ADDR_WIDTH (AW)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .fifo    (fif)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [DEPTH];
  logic [7:0] rdata_q;
  logic [7:0] wdata;
  logic [7:0] wdata_next;
  logic [7:0] exp_q [$];

  int   m_cnt, m_wa, m_ra;
  logic m_rv, m_ovf, m_unf;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // RAM model: registered read, write port tied to the same clock.
  always @(posedge clock) begin
    if (fif.write_allow) mem[fif.write_addr] <= wdata;
    if (fif.read_allow)  rdata_q <= mem[fif.read_addr];
  end

  // Monitor: every read_valid must present the oldest accepted write.
  always @(negedge clock) begin
    if (reset_n && fif.read_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rdata: read_valid with empty scoreboard at %0t", $time);
      end else begin
        chk("rdata", int'(rdata_q), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic model_reset();
    m_cnt = 0; m_wa = 0; m_ra = 0;
    m_rv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_state();
    chk("fifo_count", int'(fif.fifo_count), m_cnt);
    chk("fifo_empty", int'(fif.fifo_empty), int'(m_cnt == 0));
    chk("fifo_full",  int'(fif.fifo_full),  int'(m_cnt == DEPTH));
    chk("write_addr", int'(fif.write_addr), m_wa);
    chk("read_addr",  int'(fif.read_addr),  m_ra);
    chk("read_valid", int'(fif.read_valid), int'(m_rv));
    chk("overflow",   int'(fif.overflow),   int'(m_ovf));
    chk("underflow",  int'(fif.underflow),  int'(m_unf));
`ifdef SYNC_FIFO_ALMOST_EN
    chk("almost_full",  int'(fif.almost_full),  int'(m_cnt >= 14));
    chk("almost_empty", int'(fif.almost_empty), int'(m_cnt <= 2));
`endif
  endtask

  // One clock of stimulus; entered and left just after a falling edge.
  task automatic step(input logic we, input logic re);
    logic w_ok, r_ok;
    w_ok = we && (m_cnt < DEPTH);
    r_ok = re && (m_cnt > 0);
    fif.write_enable = we;
    fif.read_enable  = re;
    wdata = wdata_next;
    #1;
    check_state();
    chk("write_allow", int'(fif.write_allow), int'(w_ok));
    chk("read_allow",  int'(fif.read_allow),  int'(r_ok));
    if (w_ok) begin
      exp_q.push_back(wdata);
      wdata_next = wdata_next + 8'd1;
    end
    @(posedge clock);
    m_ovf = we && (m_cnt == DEPTH);
    m_unf = re && (m_cnt == 0);
    m_rv  = r_ok;
    if (w_ok) m_wa = (m_wa + 1) % DEPTH;
    if (r_ok) m_ra = (m_ra + 1) % DEPTH;
    m_cnt = m_cnt + int'(w_ok) - int'(r_ok);
    @(negedge clock);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fif.write_enable = 1'b0;
    fif.read_enable  = 1'b0;
    wdata      = 8'd0;
    wdata_next = 8'd1;
    model_reset();

    @(negedge clock);
    #1;
    check_state();
    chk("write_allow_rst", int'(fif.write_allow), 0);
    chk("read_allow_rst",  int'(fif.read_allow),  0);
    @(negedge clock);
    reset_n = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Fill to full, then one refused write.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    // Full with both requests: only the read goes.
    step(1'b1, 1'b1);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Underflow on empty, then both requests on empty.
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);

    // Walk through both threshold crossings.
    for (int i = 0; i < 4; i++)  step(1'b0, 1'b1);
    for (int i = 0; i < 13; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b0, 1'b1);

    // Interleaved traffic across the address wrap.
    for (int i = 0; i < 40; i++) step((i % 4) != 3, (i % 4) != 0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);

    // Reset mid-burst with a read_valid pending.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    #2;
    fif.write_enable = 1'b0;
    fif.read_enable  = 1'b0;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_state();
    chk("write_allow_mid_rst", int'(fif.write_allow), 0);
    chk("read_allow_mid_rst",  int'(fif.read_allow),  0);
    @(negedge clock);
    reset_n = 1'b1;
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
